wrr_sched: RTL and testbench
============================

Name: wrr_sched

Overview:
- Parametrised weighted round-robin slot scheduler; next generation of the PIM round-robin slot rotator.
- Tracks up to DEPTH indices in rotation. Each index has a per-index quantum: the number of consecutive rr_nxt grants it holds before rotation advances.
- Arbitrary-index removal and in-place weight update are supported.
- Rotation order is ascending index order with wrap-around, not insertion order.
- Sits between command queues and the PIM issue logic, and selects which bank/channel queue is serviced.

Parameters:
- DEPTH, 16: number of schedulable indices; must be at least 2; need not be a power of 2.
- WGT_W, 4: weight field width; quantum = weight + 1, range 1..2^WGT_W.
- IDX_W, $clog2(DEPTH): index width (localparam, derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rr_add  in  1  add index rr_add_val, or update its weight if already active
- rr_add_val  in  IDX_W  index to add
- rr_add_wgt  in  WGT_W  weight for rr_add_val
- rr_rmv  in  1  remove the current index (rr_idx)
- rr_rmv_any  in  1  remove index rr_rmv_val
- rr_rmv_val  in  IDX_W  index to remove
- rr_nxt  in  1  consume one grant of the current index
- rr_idx  out  IDX_W  current index; 0 when empty
- rr_vld  out  1  at least one index is active
- rr_occup  out  IDX_W+1  number of active indices
- rr_credit  out  WGT_W+1  grants remaining for rr_idx, including the present one

Behaviour:
- Clocking and reset:
  - Single clock; every state element updates on the rising edge of clk.
  - rst is synchronous. It clears the active mask, all weights, cur, credit and occup.
  - Reset values: rr_idx=0, rr_vld=0, rr_occup=0, rr_credit=0.
  - Inputs in a reset cycle are ignored; reset mid-operation discards all rotation state.
- State: active[DEPTH], wgt[DEPTH], cur, credit, occup. All outputs come straight from registers; the effect of any request is visible the next cycle.
- Request masks per cycle:
  - rmv_mask = (rr_rmv && rr_vld ? bit cur : 0) | (rr_rmv_any && active[rr_rmv_val] ? bit rr_rmv_val : 0).
  - add_mask = rr_add && rr_add_val<DEPTH ? bit rr_add_val : 0.
  - active_nxt = (active & ~rmv_mask) | add_mask. Add wins over remove of the same index.
- Requests that are ignored:
  - Any index >= DEPTH, for both add and remove.
  - Removal of an inactive index.
  - rr_nxt or rr_rmv while rr_vld=0.
- Weights:
  - An add of an active index overwrites wgt only. occup, cur and credit are unchanged.
  - The new weight applies at that index's next credit reload.
- Next-index search (nsel): first set bit of active_nxt scanning cur+1, cur+2, … modulo DEPTH, ending at cur inclusive. No bit set gives none.
- cur/credit update, first match wins:
  1. rr_vld=0 and active_nxt nonzero: cur <= nsel, credit <= quantum(nsel).
  2. Current index in rmv_mask (via rr_rmv or rr_rmv_any): cur <= nsel, credit <= quantum(nsel); rr_nxt that cycle is absorbed. If nsel is none: cur <= 0, credit <= 0.
  3. rr_nxt and credit>1: credit <= credit-1.
  4. rr_nxt and credit==1: cur <= nsel, credit <= quantum(nsel). With one active index this re-selects cur and reloads its credit.
  5. Otherwise cur and credit hold.
- Quantum source at a reload: if the selected index is added this cycle, the quantum uses rr_add_wgt; otherwise it uses the stored wgt.
- occup <= popcount(active_nxt); rr_vld <= active_nxt != 0.
- Removing a non-current index while rr_nxt is asserted: both take effect, so credit decrements or rotation advances skipping the removed index.

Decomposition:
- Package wrr_pkg: IDX_W/quantum width helper function, and quantum(wgt) function (wgt+1, widened to WGT_W+1).
- Sub-module rr_next_sel, combinational: rotate mask by cur+1, priority-encode, un-rotate modulo DEPTH; outputs index and found.
- DEPTH is not a power of 2 in general, so modulo wrap is explicit.

Test Plan:
- Weighted sequence: DEPTH=16, WGT_W=4. Add idx3 wgt0, next cycle add idx7 wgt2 -> rr_idx=3, rr_credit=1, occup=2. Then nxt x4 -> rr_idx 7 (cr3), 7 (cr2), 7 (cr1), 3 (cr1).
- Wrap-around: add 14 wgt0, then 1 wgt0 -> rr_idx=14; nxt -> 1; nxt -> 14.
- Drain: single idx5 active, rr_rmv -> rr_vld=0, rr_idx=0, rr_credit=0, occup=0. A following rr_nxt changes nothing.
- Simultaneous events:
  - idx2 (cur, cr1) and idx9 (wgt1) active; rr_rmv_any val9 plus rr_nxt -> rr_idx=2, credit reloaded to 1, occup=1.
  - Alone idx2 with rr_rmv plus rr_add val2 wgt3 -> rr_idx=2, rr_credit=4, occup=1.
- Weight update and out-of-range, DEPTH=12: add 4 wgt0, then add 4 wgt2 -> occup stays 1. After the next reload rr_credit=3. Add 13 -> ignored, occup=1.
- Reset mid-operation: three indices active, credit=2, assert rst with rr_add -> next cycle all outputs 0 and the add is discarded.

Source files
------------

// File: rtl/wrr_pkg.sv
// Shared widths and quantum arithmetic for the weighted round-robin scheduler.
package wrr_pkg;

    // Widest weight field the quantum helper is sized for.
    localparam int MAX_WGT_W = 16;

    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int quantum_width(input int wgt_w);
        return wgt_w + 1;
    endfunction

    // A weight of w grants w+1 consecutive slots.
    function automatic logic [MAX_WGT_W:0] quantum(input logic [MAX_WGT_W-1:0] wgt);
        return {1'b0, wgt} + (MAX_WGT_W+1)'(1);
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Finds the first set bit of mask strictly after cur, wrapping modulo DEPTH
// and ending at cur itself.
module rr_next_sel #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] mask,
    input  logic [IDX_W-1:0] cur,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(DEPTH - 1);
    localparam logic [IDX_W:0] DEP  = (IDX_W+1)'(DEPTH);

    logic [IDX_W:0]   start;
    logic [IDX_W:0]   pos;
    logic [DEPTH-1:0] rot;
    logic [IDX_W-1:0] off;

    // DEPTH need not be a power of two, so every wrap is an explicit compare.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        start = ({1'b0, cur} >= LAST) ? '0 : {1'b0, cur} + (IDX_W+1)'(1);
        rot   = DEPTH'({mask, mask} >> start);
        found = 1'b0;
        off   = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                off   = IDX_W'(j);
            end
        end
        pos = start + {1'b0, off};
        if (pos >= DEP) begin
            pos = pos - DEP;
        end
        idx = IDX_W'(pos);
    end

endmodule

// File: rtl/wrr_sched.sv
// Weighted round-robin slot scheduler: ascending-index rotation where each
// active index holds rr_nxt grants for weight+1 turns.
module wrr_sched
    import wrr_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WGT_W = 4,
    localparam int IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rr_add,
    input  logic [IDX_W-1:0] rr_add_val,
    input  logic [WGT_W-1:0] rr_add_wgt,
    input  logic             rr_rmv,
    input  logic             rr_rmv_any,
    input  logic [IDX_W-1:0] rr_rmv_val,
    input  logic             rr_nxt,
    output logic [IDX_W-1:0] rr_idx,
    output logic             rr_vld,
    output logic [IDX_W:0]   rr_occup,
    output logic [WGT_W:0]   rr_credit
);

    localparam int             Q_W   = quantum_width(WGT_W);
    localparam logic [IDX_W:0] DEP_V = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0] active;
    logic [WGT_W-1:0] wgt [DEPTH];
    logic [IDX_W-1:0] cur;
    logic [Q_W-1:0]   credit;
    logic [IDX_W:0]   occup;
    logic             vld;

    logic [DEPTH-1:0] rmv_mask;
    logic [DEPTH-1:0] add_mask;
    logic [DEPTH-1:0] active_nxt;
    logic             add_ok;
    logic [IDX_W-1:0] nsel_idx;
    logic             nsel_found;
    logic [WGT_W-1:0] nsel_wgt;
    logic [Q_W-1:0]   nsel_q;

    always_comb begin
        add_ok   = rr_add && ({1'b0, rr_add_val} < DEP_V);
        rmv_mask = '0;
        add_mask = '0;
        if (rr_rmv && vld) begin
            rmv_mask[cur] = 1'b1;
        end
        if (rr_rmv_any && ({1'b0, rr_rmv_val} < DEP_V) && active[rr_rmv_val]) begin
            rmv_mask[rr_rmv_val] = 1'b1;
        end
        if (add_ok) begin
            add_mask[rr_add_val] = 1'b1;
        end
        // An add of the same index overrides its removal.
        active_nxt = (active & ~rmv_mask) | add_mask;
    end

    rr_next_sel #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_next_sel (
        .mask  (active_nxt),
        .cur   (cur),
        .idx   (nsel_idx),
        .found (nsel_found)
    );

    // A weight written this cycle is the one used if this cycle reloads that index.
    assign nsel_wgt = (add_ok && rr_add_val == nsel_idx) ? rr_add_wgt : wgt[nsel_idx];
    assign nsel_q   = Q_W'(quantum(MAX_WGT_W'(nsel_wgt)));

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
        if (rst) begin
            active <= '0;
            // NOTE: the weight array is small and register-built, so it is cleared on reset like any other state.
            for (int i = 0; i < DEPTH; i++) begin
                wgt[i] <= '0;
            end
            cur    <= '0;
            credit <= '0;
            occup  <= '0;
            vld    <= 1'b0;
        end else begin
            active <= active_nxt;
            if (add_ok) begin
                wgt[rr_add_val] <= rr_add_wgt;
            end
            occup <= (IDX_W+1)'($countones(active_nxt));
            vld   <= |active_nxt;

            if (!vld) begin
                if (nsel_found) begin
                    cur    <= nsel_idx;
                    credit <= nsel_q;
                end
            end else if (rmv_mask[cur]) begin
                cur    <= nsel_found ? nsel_idx : '0;
                credit <= nsel_found ? nsel_q : '0;
            end else if (rr_nxt && credit > Q_W'(1)) begin
                credit <= credit - Q_W'(1);
            end else if (rr_nxt) begin
                cur    <= nsel_idx;
                credit <= nsel_q;
            end
        end
    end

    assign rr_idx    = cur;
    assign rr_vld    = vld;
    assign rr_occup  = occup;
    assign rr_credit = credit;

endmodule

// File: tb/tb_wrr_sched.sv
// Scoreboard bench for wrr_sched: one stimulus stream drives a DEPTH=16 and a
// DEPTH=12 instance, each checked against an array-based reference model.
module tb_wrr_sched;

    typedef struct {
        bit rst;
        bit add;
        int av;
        int aw;
        bit rmv;
        bit rmv_any;
        int rv;
        bit nxt;
    } stim_t;

    typedef struct {
        int idx;
        int vld;
        int occup;
        int credit;
    } out_t;

    typedef struct {
        out_t o [2];
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rr_add = 1'b0;
    logic [3:0] rr_add_val = '0;
    logic [3:0] rr_add_wgt = '0;
    logic       rr_rmv = 1'b0;
    logic       rr_rmv_any = 1'b0;
    logic [3:0] rr_rmv_val = '0;
    logic       rr_nxt = 1'b0;

    logic [3:0] idx0, idx1;
    logic       vld0, vld1;
    logic [4:0] occ0, occ1;
    logic [4:0] cr0, cr1;

    int n_cmp = 0;
    int n_err = 0;
    exp_t exp_q [$];

    // Reference state, sized for the larger instance.
    bit m_act [2][16];
    int m_w   [2][16];
    int m_cur [2];
    int m_cred[2];

    always #5 clk = ~clk;

    wrr_sched #(.DEPTH(16), .WGT_W(4)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .rr_add     (rr_add),
        .rr_add_val (rr_add_val),
        .rr_add_wgt (rr_add_wgt),
        .rr_rmv     (rr_rmv),
        .rr_rmv_any (rr_rmv_any),
        .rr_rmv_val (rr_rmv_val),
        .rr_nxt     (rr_nxt),
        .rr_idx     (idx0),
        .rr_vld     (vld0),
        .rr_occup   (occ0),
        .rr_credit  (cr0)
    );

    wrr_sched #(.DEPTH(12), .WGT_W(4)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .rr_add     (rr_add),
        .rr_add_val (rr_add_val),
        .rr_add_wgt (rr_add_wgt),
        .rr_rmv     (rr_rmv),
        .rr_rmv_any (rr_rmv_any),
        .rr_rmv_val (rr_rmv_val),
        .rr_nxt     (rr_nxt),
        .rr_idx     (idx1),
        .rr_vld     (vld1),
        .rr_occup   (occ1),
        .rr_credit  (cr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of requests to the model of instance d and returns
    // the outputs visible after the clock edge.
    function automatic out_t model_step(input int d, input int depth, input stim_t s);
        out_t r;
        bit   nx [16];
        bit   vld, cur_rm, add_ok;
        int   cnt, nsel, q, j;
        if (s.rst) begin
            for (int i = 0; i < 16; i++) begin
                m_act[d][i] = 0;
                m_w[d][i]   = 0;
            end
            m_cur[d]  = 0;
            m_cred[d] = 0;
        end else begin
            cnt = 0;
            for (int i = 0; i < depth; i++) cnt += int'(m_act[d][i]);
            vld = (cnt > 0);
            for (int i = 0; i < 16; i++) nx[i] = m_act[d][i];
            cur_rm = 0;
            if (s.rmv && vld) begin
                nx[m_cur[d]] = 0;
                cur_rm = 1;
            end
            if (s.rmv_any && s.rv < depth && m_act[d][s.rv]) begin
                nx[s.rv] = 0;
                if (s.rv == m_cur[d]) cur_rm = 1;
            end
            add_ok = s.add && (s.av < depth);
            if (add_ok) nx[s.av] = 1;

            nsel = -1;
            for (int k = 1; k <= depth; k++) begin
                j = (m_cur[d] + k) % depth;
                if (nsel < 0 && nx[j]) nsel = j;
            end
            if (nsel < 0)                      q = 0;
            else if (add_ok && s.av == nsel)   q = s.aw + 1;
            else                               q = m_w[d][nsel] + 1;

            if (!vld) begin
                if (nsel >= 0) begin
                    m_cur[d]  = nsel;
                    m_cred[d] = q;
                end
            end else if (cur_rm) begin
                m_cur[d]  = (nsel >= 0) ? nsel : 0;
                m_cred[d] = (nsel >= 0) ? q : 0;
            end else if (s.nxt && m_cred[d] > 1) begin
                m_cred[d] = m_cred[d] - 1;
            end else if (s.nxt) begin
                m_cur[d]  = nsel;
                m_cred[d] = q;
            end

            if (add_ok) m_w[d][s.av] = s.aw;
            for (int i = 0; i < 16; i++) m_act[d][i] = nx[i];
        end
        cnt = 0;
        for (int i = 0; i < depth; i++) cnt += int'(m_act[d][i]);
        r.idx    = m_cur[d];
        r.occup  = cnt;
        r.vld    = (cnt > 0) ? 1 : 0;
        r.credit = m_cred[d];
        return r;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge clk);
        #1;
        rst        = s.rst;
        rr_add     = s.add;
        rr_add_val = 4'(s.av);
        rr_add_wgt = 4'(s.aw);
        rr_rmv     = s.rmv;
        rr_rmv_any = s.rmv_any;
        rr_rmv_val = 4'(s.rv);
        rr_nxt     = s.nxt;
        e.o[0] = model_step(0, 16, s);
        e.o[1] = model_step(1, 12, s);
        exp_q.push_back(e);
    endtask

    // Argument order: rst, add, add_val, add_wgt, rmv, rmv_any, rmv_val, nxt.
    task automatic op(input bit r, input bit a, input int av, input int aw,
                      input bit rm, input bit ra, input int rv, input bit n);
        stim_t s;
        s.rst = r; s.add = a; s.av = av; s.aw = aw;
        s.rmv = rm; s.rmv_any = ra; s.rv = rv; s.nxt = n;
        drive(s);
    endtask

    task automatic do_rst();      op(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic idle();        op(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic nxt();         op(0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic add(input int v, input int w); op(0, 1, v, w, 0, 0, 0, 0); endtask

    // Monitor: the DUT presents fresh outputs every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("d16.rr_idx",    32'(idx0), 32'(e.o[0].idx));
            check("d16.rr_vld",    32'(vld0), 32'(e.o[0].vld));
            check("d16.rr_occup",  32'(occ0), 32'(e.o[0].occup));
            check("d16.rr_credit", 32'(cr0),  32'(e.o[0].credit));
            check("d12.rr_idx",    32'(idx1), 32'(e.o[1].idx));
            check("d12.rr_vld",    32'(vld1), 32'(e.o[1].vld));
            check("d12.rr_occup",  32'(occ1), 32'(e.o[1].occup));
            check("d12.rr_credit", 32'(cr1),  32'(e.o[1].credit));
        end
    end

    initial begin
        stim_t s;
        do_rst();
        idle();

        // Weighted sequence: 3 (quantum 1) and 7 (quantum 3).
        do_rst();
        add(3, 0);
        add(7, 2);
        repeat (4) nxt();
        idle();

        // Wrap-around between 14 and 1.
        do_rst();
        add(14, 0);
        add(1, 0);
        nxt();
        nxt();

        // Drain the last index, then a grant on an empty scheduler.
        do_rst();
        add(5, 0);
        idle();
        op(0, 0, 0, 0, 1, 0, 0, 0);
        nxt();

        // Remove a non-current index together with a final grant.
        do_rst();
        add(2, 0);
        add(9, 1);
        op(0, 0, 0, 0, 0, 1, 9, 1);

        // Remove and re-add the sole current index in one cycle.
        do_rst();
        add(2, 0);
        op(0, 1, 2, 3, 1, 0, 0, 0);
        idle();

        // Weight update applies at next reload; out-of-range add.
        do_rst();
        add(4, 0);
        add(4, 2);
        nxt();
        add(13, 5);
        nxt();

        // Reset mid-operation discards an accompanying add.
        do_rst();
        add(1, 1);
        add(6, 0);
        add(10, 3);
        op(1, 1, 8, 2, 0, 0, 0, 0);
        idle();

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            s.rst     = ($urandom_range(0, 299) == 0);
            s.add     = ($urandom_range(0, 99) < 35);
            s.av      = $urandom_range(0, 15);
            s.aw      = $urandom_range(0, 15);
            s.rmv     = ($urandom_range(0, 99) < 8);
            s.rmv_any = ($urandom_range(0, 99) < 15);
            s.rv      = $urandom_range(0, 15);
            s.nxt     = ($urandom_range(0, 99) < 60);
            drive(s);
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
